// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-control bus between pipeline datapath and sequencer
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_counters;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               mem_req, mem_ready, clr_counters,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, state, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               mem_req, mem_ready, clr_counters,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               mem_timeout, state, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencer: load-use stall, branch flush, memory wait with watchdog
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int WCW = 16;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt, w_wait_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0] r_stall, w_stall_nxt;
    logic [CNT_W-1:0] r_flush, w_flush_nxt;

    logic w_hold, w_load_use, w_branch_flush;
    logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_flush, w_pipe_hold;

    assign w_hold = (r_state == ST_RUN  && bus.mem_req && !bus.mem_ready) ||
                    (r_state == ST_WAIT && !bus.mem_ready) ||
                    (r_state == ST_ERR);

    assign w_load_use = bus.ex_mem_read && (bus.ex_rt != '0) &&
                        ((bus.ex_rt == bus.id_rs) ||
                         (bus.id_uses_rt && bus.ex_rt == bus.id_rt));

    // Hold wins over branch, branch wins over load-use (the dependent instr is flushed anyway).
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_pipe_hold    = 1'b0;
        w_branch_flush = 1'b0;
        if (reset) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_hold) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_hold   = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_branch_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_wait_nxt  = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt   = ST_ERR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + WCW'(1);
                end
            end
            default: w_state_nxt = ST_ERR;
        endcase

        w_stall_nxt = r_stall;
        w_flush_nxt = r_flush;
        if (bus.clr_counters) begin
            w_stall_nxt = '0;
            w_flush_nxt = '0;
        end else begin
            if (!w_pc_write && !(&r_stall))
                w_stall_nxt = r_stall + CNT_W'(1);
            if (w_branch_flush && !(&r_flush))
                w_flush_nxt = r_flush + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_stall    <= '0;
            r_flush    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
            r_stall    <= w_stall_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.pipe_hold    = w_pipe_hold;
    assign bus.mem_timeout  = r_timeout;
    assign bus.state        = r_state;
    assign bus.stall_cycles = r_stall;
    assign bus.flush_count  = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int TO    = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout;
        int state, stall, flush;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 running, 1 waiting on memory, 2 dead; waited = hold cycles spent on this access.
    int m_mode = 0, m_waited = 0, m_stall = 0, m_flush = 0;
    bit m_to = 0;

    task automatic cycle(input bit rst, input int rs, input int rt, input bit uses_rt,
                         input bit mr, input int exrt, input bit br,
                         input bit req, input bit rdy, input bit clr);
        exp_t e;
        bit hold, lu;
        @(posedge clk);
        #1;
        reset               = rst;
        bus.id_rs           = REG_W'(rs);
        bus.id_rt           = REG_W'(rt);
        bus.id_uses_rt      = uses_rt;
        bus.ex_mem_read     = mr;
        bus.ex_rt           = REG_W'(exrt);
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
        bus.clr_counters    = clr;

        e.mem_timeout = m_to;
        e.state = m_mode;
        e.stall = m_stall;
        e.flush = m_flush;
        hold = (m_mode == 2) || (m_mode == 1 && !rdy) || (m_mode == 0 && req && !rdy);
        lu   = mr && exrt != 0 && (exrt == rs || (uses_rt && exrt == rt));
        if (rst) begin
            e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 1; e.id_ex_flush = 1; e.pipe_hold = 0;
        end else if (hold) begin
            e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_flush = 0; e.pipe_hold = 1;
        end else if (br) begin
            e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 1; e.pipe_hold = 0;
        end else if (lu) begin
            e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_flush = 1; e.pipe_hold = 0;
        end else begin
            e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_flush = 0; e.pipe_hold = 0;
        end
        exp_q.push_back(e);

        if (rst) begin
            m_mode = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e.pc_write) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                if (!hold && br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            end
            if (m_mode == 0 && req && !rdy) begin
                m_mode = 1; m_waited = 1;
            end else if (m_mode == 1) begin
                if (rdy) m_mode = 0;
                else begin
                    m_waited++;
                    if (m_waited >= TO) begin m_mode = 2; m_to = 1; end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_write",     int'(bus.pc_write),     int'(e.pc_write));
            chk("if_id_write",  int'(bus.if_id_write),  int'(e.if_id_write));
            chk("if_id_flush",  int'(bus.if_id_flush),  int'(e.if_id_flush));
            chk("id_ex_flush",  int'(bus.id_ex_flush),  int'(e.id_ex_flush));
            chk("pipe_hold",    int'(bus.pipe_hold),    int'(e.pipe_hold));
            chk("mem_timeout",  int'(bus.mem_timeout),  int'(e.mem_timeout));
            chk("state",        int'(bus.state),        e.state);
            chk("stall_cycles", int'(bus.stall_cycles), e.stall);
            chk("flush_count",  int'(bus.flush_count),  e.flush);
        end
    end

    initial begin
        reset = 1'b1;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
        bus.ex_rt = '0; bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
        bus.clr_counters = 0;
        repeat (2) @(posedge clk);

        // reset held two cycles, then release
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs, then same with r0 as destination
        cycle(0, 8, 3, 0, 1, 8, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 5, 9, 1, 1, 9, 0, 0, 0, 0);
        cycle(0, 5, 9, 0, 1, 9, 0, 0, 0, 0);
        idle(1);

        // branch overrides load-use
        cycle(0, 8, 0, 0, 1, 8, 1, 0, 0, 0);
        idle(1);

        // three memory-wait cycles, release with a branch
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 8, 0, 0, 1, 8, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);

        // watchdog: memory never answers
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 0, i[0], 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cycle(0, 8, 0, 0, 1, 8, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // stall counter saturation, then clear beats a simultaneous stall
        for (int i = 0; i < 20; i++) cycle(0, 8, 0, 0, 1, 8, 0, 0, 0, 0);
        cycle(0, 8, 0, 0, 1, 8, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 18; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit rst = ($urandom_range(0, 79) == 0);
            bit clr = ($urandom_range(0, 39) == 0);
            int rs  = $urandom_range(0, 7);
            int rt  = $urandom_range(0, 7);
            int ert = $urandom_range(0, 7);
            bit ur  = $urandom_range(0, 1);
            bit mr  = $urandom_range(0, 1);
            bit br  = ($urandom_range(0, 5) == 0);
            bit req = ($urandom_range(0, 3) == 0);
            bit rdy = ($urandom_range(0, 9) < 6);
            cycle(rst, rs, rt, ur, mr, ert, br, req, rdy, clr);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Drives write-enable, flush and hold controls for the PC, IF/ID, ID/EX and downstream pipeline registers.
- Handles load-use stalls, taken-branch flushes and multi-cycle memory waits, with a timeout watchdog.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- REG_W, 5, register-specifier width.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before error; legal range 2..65535.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  destination register of the load in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- clr_counters  in  1  synchronous clear of the performance counters.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  load zero into IF/ID.
- id_ex_flush  out  1  load zero into ID/EX (bubble).
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky watchdog error.
- state  out  2  FSM state: 0 RUN, 1 WAIT, 2 ERR.
- stall_cycles  out  CNT_W  saturating stall-cycle count.
- flush_count  out  CNT_W  saturating branch-flush count.

Behaviour:
- Control outputs are combinational from the current state and inputs (zero latency), so they act in the same cycle the hazard is present. State, the wait counter, mem_timeout and the perf counters are registered.
- Reset (while reset=1, takes priority over everything):
  - Outputs forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0.
  - Next edge: state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
- hold condition: (state==RUN && mem_req && !mem_ready) || (state==WAIT && !mem_ready) || state==ERR.
- Priority, highest first: hold > branch > load-use > normal.
  - Hold: pc_write=0, if_id_write=0, pipe_hold=1, no flushes. Branch and load-use inputs are ignored while holding; they are re-evaluated in the release cycle.
  - Branch (ex_branch_taken): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. Any simultaneous load-use is ignored because the dependent instruction is flushed.
  - Load-use: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)). Outputs pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, pipe_hold=0. Lasts exactly one cycle naturally, since the next EX slot holds the bubble.
  - Normal: pc_write=1, if_id_write=1, all other controls 0.
- FSM:
  - RUN -> WAIT when mem_req && !mem_ready; wait_cnt<=1.
  - RUN stays RUN when mem_req && mem_ready (single-cycle access, no hold).
  - WAIT -> RUN when mem_ready. That cycle is the release cycle: pipe_hold=0 and branch/load-use are evaluated normally.
  - WAIT with !mem_ready: wait_cnt<=wait_cnt+1. If wait_cnt==MEM_TIMEOUT-1, go to ERR and set mem_timeout<=1.
  - ERR: absorbing. Hold is asserted permanently; only reset exits.
  - mem_req is don't-care while in WAIT.
- Counters:
  - stall_cycles increments on every cycle with pc_write=0 outside reset (hold or load-use), ERR included.
  - flush_count increments on each branch-flush cycle.
  - Both saturate at all-ones and do not wrap.
  - clr_counters zeroes both on the next edge and overrides an increment in the same cycle. It does not affect state or mem_timeout.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during reset pc_write=0 and both flushes=1. After release: pc_write=1, if_id_write=1, state=0, counters=0.
- ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> both flushes=1, pc_write=1; flush_count=1, stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_branch_taken=1:
  - pipe_hold=1 for 3 cycles and state=1.
  - Release cycle flushes, state returns to 0.
  - stall_cycles=3, flush_count=1.
- MEM_TIMEOUT=4, mem_req=1 and mem_ready never asserted -> state=2 and mem_timeout=1 after 4 wait cycles, hold persists. A later mem_ready changes nothing; reset clears.
- Force stall_cycles to all-ones (CNT_W=4 build, 20 stall cycles) -> holds at 15. Then clr_counters=1 with a stall in the same cycle -> 0.
